// File: rtl/game_timer_display.sv
// game_timer_display: BCD survival timer with personal-best tracking and a
// multiplexed seven-segment driver showing current and best time together.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   restart      single-cycle pulse, starts a new run (clears cur_time)
//   dead         level, high while the player is dead; rising edge ends a run
//   running      high while a run is in progress
//   best_valid   high once at least one run has been recorded
//   cur_time     current time, packed BCD, digit 0 in the LSBs
//   best_time    best time, packed BCD
//   An           active-low digit enables, one-hot-low
//   SSD_CATHODES active-low {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}
module game_timer_display #(
    parameter int CLK_HZ      = 100000000,
    parameter int TICK_HZ     = 100,
    parameter int TIME_DIGITS = 4,
    parameter int SCAN_DIV    = 100000,
    parameter int DP_POS      = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       restart,
    input  logic                       dead,
    output logic                       running,
    output logic                       best_valid,
    output logic [4*TIME_DIGITS-1:0]   cur_time,
    output logic [4*TIME_DIGITS-1:0]   best_time,
    output logic [2*TIME_DIGITS-1:0]   An,
    output logic [7:0]                 SSD_CATHODES
);

    localparam int TW       = 4 * TIME_DIGITS;
    localparam int NDIG     = 2 * TIME_DIGITS;
    localparam int TICK_DIV = (CLK_HZ / TICK_HZ > 0) ? CLK_HZ / TICK_HZ : 1;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SDIV     = (SCAN_DIV > 0) ? SCAN_DIV : 1;
    localparam int SW       = (SDIV > 1) ? $clog2(SDIV) : 1;
    localparam int IW       = $clog2(NDIG);

    localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0]   SCAN_LAST = SW'(SDIV - 1);
    localparam logic [IW-1:0]   IDX_LAST  = IW'(NDIG - 1);
    localparam logic [NDIG-1:0] AN_ONE    = NDIG'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic            dead_q;
    logic            dead_rise;
    logic            in_run;
    logic            tick_en;
    logic            die;
    logic            count;
    logic            take_best;
    logic [PW-1:0]   presc;
    logic [TW-1:0]   cur_inc;
    logic            inc_carry;
    logic            all_nines;
    logic [SW-1:0]   scan_cnt;
    logic [IW-1:0]   scan_idx;
    logic [3:0]      digit;
    logic            dash;
    logic            dp_on;
    logic [6:0]      seg;

    // ---------------------------------------------------------------
    // Run control
    // ---------------------------------------------------------------
    assign dead_rise = dead & ~dead_q;
    assign in_run    = (state == RUN);
    assign tick_en   = in_run & (presc == TICK_LAST);

    // A restart in the same cycle as a dead edge keeps the run alive,
    // so the end-of-run event is qualified by !restart.
    assign die       = in_run & dead_rise & ~restart;

    // A tick that coincides with the end of the run is dropped so the
    // recorded time is exactly what was on display.
    assign count     = tick_en & ~die & ~restart;

    assign take_best = die & (~best_valid | (cur_time > best_time));

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (restart) state_nx = RUN;
            end
            RUN: begin
                if (restart)        state_nx = RUN;
                else if (dead_rise) state_nx = DEAD;
            end
            DEAD: begin
                if (restart) state_nx = RUN;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            running <= 1'b0;
            dead_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            running <= (state_nx == RUN);
            dead_q  <= dead;
        end
    end

    // ---------------------------------------------------------------
    // Tick prescaler
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
        end else if (restart) begin
            presc <= '0;
        end else if (in_run) begin
            if (presc == TICK_LAST) presc <= '0;
            else                    presc <= presc + PW'(1);
        end
    end

    // ---------------------------------------------------------------
    // BCD ripple increment with saturation at all nines
    // ---------------------------------------------------------------
    always_comb begin
        cur_inc   = cur_time;
        inc_carry = 1'b1;
        for (int i = 0; i < TIME_DIGITS; i++) begin
            if (inc_carry) begin
                if (cur_time[4*i +: 4] == 4'd9) begin
                    cur_inc[4*i +: 4] = 4'd0;
                end else begin
                    cur_inc[4*i +: 4] = cur_time[4*i +: 4] + 4'd1;
                    inc_carry = 1'b0;
                end
            end
        end
    end

    always_comb begin
        all_nines = 1'b1;
        for (int i = 0; i < TIME_DIGITS; i++) begin
            if (cur_time[4*i +: 4] != 4'd9) all_nines = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_time <= '0;
        end else if (restart) begin
            cur_time <= '0;
        end else if (count && !all_nines) begin
            cur_time <= cur_inc;
        end
    end

    // Packed BCD compares correctly as an unsigned binary vector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_time  <= '0;
            best_valid <= 1'b0;
        end else if (take_best) begin
            best_time  <= cur_time;
            best_valid <= 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Digit scan
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            if (scan_idx == IDX_LAST) scan_idx <= '0;
            else                      scan_idx <= scan_idx + IW'(1);
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    // Lower indices show the current field, upper ones the best field.
    always_comb begin
        digit = 4'd0;
        dash  = 1'b0;
        dp_on = 1'b0;
        for (int i = 0; i < TIME_DIGITS; i++) begin
            if (scan_idx == IW'(i)) begin
                digit = cur_time[4*i +: 4];
                dp_on = (i == DP_POS);
            end
            if (scan_idx == IW'(TIME_DIGITS + i)) begin
                digit = best_time[4*i +: 4];
                dash  = ~best_valid;
                dp_on = (i == DP_POS);
            end
        end
    end

    // Active-low {a,b,c,d,e,f,g}; out-of-range BCD blanks.
    always_comb begin
        seg = 7'b1111111;
        if (dash) begin
            seg = 7'b1111110;
        end else begin
            case (digit)
                4'd0:    seg = 7'b0000001;
                4'd1:    seg = 7'b1001111;
                4'd2:    seg = 7'b0010010;
                4'd3:    seg = 7'b0000110;
                4'd4:    seg = 7'b1001100;
                4'd5:    seg = 7'b0100100;
                4'd6:    seg = 7'b0100000;
                4'd7:    seg = 7'b0001111;
                4'd8:    seg = 7'b0000000;
                4'd9:    seg = 7'b0000100;
                default: seg = 7'b1111111;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            An           <= '1;
            SSD_CATHODES <= 8'hFF;
        end else begin
            An           <= ~(AN_ONE << scan_idx);
            SSD_CATHODES <= {seg, ~dp_on};
        end
    end

endmodule

// File: tb/tb_game_timer_display.sv
// tb_game_timer_display: randomized and directed bench for game_timer_display
// against a tick-count reference model.
module tb_game_timer_display;

    localparam int DIV  = 10;
    localparam int SDIV = 4;
    localparam int DPP  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        restart = 1'b0;
    logic        dead = 1'b0;
    logic        running;
    logic        best_valid;
    logic [15:0] cur_time;
    logic [15:0] best_time;
    logic [7:0]  an;
    logic [7:0]  cath;

    logic        restart_f = 1'b0;
    logic        dead_f = 1'b0;
    logic        running_f;
    logic        best_valid_f;
    logic [15:0] cur_time_f;
    logic [15:0] best_time_f;
    logic [7:0]  an_f;
    logic [7:0]  cath_f;

    int checks = 0;
    int errors = 0;

    // model of the main instance
    bit m_run;
    int m_cycles;
    int m_best;
    bit m_bv;
    bit m_prev_dead;
    int m_n;

    int n_f;

    logic [6:0] seg_lut [0:9] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    game_timer_display #(
        .CLK_HZ(1000), .TICK_HZ(100), .TIME_DIGITS(4),
        .SCAN_DIV(SDIV), .DP_POS(DPP)
    ) dut (
        .clk(clk), .rst(rst), .restart(restart), .dead(dead),
        .running(running), .best_valid(best_valid),
        .cur_time(cur_time), .best_time(best_time),
        .An(an), .SSD_CATHODES(cath)
    );

    game_timer_display #(
        .CLK_HZ(100), .TICK_HZ(100), .TIME_DIGITS(4),
        .SCAN_DIV(SDIV), .DP_POS(DPP)
    ) dut_fast (
        .clk(clk), .rst(rst), .restart(restart_f), .dead(dead_f),
        .running(running_f), .best_valid(best_valid_f),
        .cur_time(cur_time_f), .best_time(best_time_f),
        .An(an_f), .SSD_CATHODES(cath_f)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) n_f <= 0;
        else      n_f <= n_f + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int m_ticks();
        int t;
        t = m_cycles / DIV;
        return (t > 9999) ? 9999 : t;
    endfunction

    // {An, cathodes} after clock edge n since reset release, given the
    // time values (as integers) held before that edge.
    function automatic logic [15:0] exp_scan(input int n, input int cur,
                                             input int best, input bit bv);
        int idx;
        int pos;
        int v;
        logic [7:0] a;
        logic [6:0] s;
        bit dp;
        if (n <= 0) return 16'hFFFF;
        idx = ((n - 1) / SDIV) % 8;
        pos = idx % 4;
        v = (idx < 4) ? cur : best;
        for (int i = 0; i < pos; i++) v = v / 10;
        a = ~(8'd1 << idx);
        if (idx >= 4 && !bv) s = 7'b1111110;
        else                 s = seg_lut[v % 10];
        dp = (pos == DPP) ? 1'b0 : 1'b1;
        return {a, s, dp};
    endfunction

    task automatic model_reset();
        m_run = 0;
        m_cycles = 0;
        m_best = 0;
        m_bv = 0;
        m_prev_dead = 0;
        m_n = 0;
    endtask

    // one clock: drive at negedge, update model at edge, compare after it
    task automatic step(input bit r, input bit d);
        logic [15:0] es;
        int t;
        restart = r;
        dead = d;
        es = exp_scan(m_n + 1, m_ticks(), m_best, m_bv);
        @(posedge clk);
        m_n++;
        if (r) begin
            m_run = 1;
            m_cycles = 0;
        end else if (m_run && d && !m_prev_dead) begin
            m_run = 0;
            t = m_ticks();
            if (!m_bv || t > m_best) begin
                m_best = t;
                m_bv = 1;
            end
        end else if (m_run) begin
            m_cycles++;
        end
        m_prev_dead = d;
        #1;
        check("cur_time", cur_time, to_bcd(m_ticks()));
        check("best_time", best_time, to_bcd(m_best));
        check("best_valid", best_valid, m_bv);
        check("running", running, m_run);
        check("an", an, es[15:8]);
        check("cathodes", cath, es[7:0]);
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit d);
        repeat (n) step(1'b0, d);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        restart = 1'b0;
        dead = 1'b0;
        #1;
        check("rst_cur", cur_time, 16'h0000);
        check("rst_best", best_time, 16'h0000);
        check("rst_bv", best_valid, 1'b0);
        check("rst_run", running, 1'b0);
        check("rst_an", an, 8'hFF);
        check("rst_cath", cath, 8'hFF);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic dl;
        logic rr;
        logic [15:0] es;
        int pre;

        @(negedge clk);
        do_reset();

        // counting and carry
        step(1, 0);
        run(1230, 0);
        check("cnt_0123", cur_time, 16'h0123);
        step(1, 0);
        run(990, 0);
        check("cnt_0099", cur_time, 16'h0099);
        run(10, 0);
        check("carry_0100", cur_time, 16'h0100);

        // asynchronous reset in the middle of a run
        step(1, 0);
        run(370, 0);
        check("pre_rst_0037", cur_time, 16'h0037);
        do_reset();

        // dead edge on the tick cycle
        step(1, 0);
        run(99, 0);
        step(0, 1);
        check("tickdead_best", best_time, 16'h0009);
        check("tickdead_cur", cur_time, 16'h0009);
        run(25, 1);
        check("frozen_cur", cur_time, 16'h0009);

        // best tracking across runs
        step(1, 0); run(500, 0); step(0, 1);
        check("best_0050", best_time, 16'h0050);
        check("bv_set", best_valid, 1'b1);
        step(1, 0); run(300, 0); step(0, 1);
        check("best_keep", best_time, 16'h0050);
        step(1, 0); run(800, 0); step(0, 1);
        check("best_0080", best_time, 16'h0080);
        step(1, 0); run(800, 0); step(0, 1);
        check("best_equal", best_time, 16'h0080);

        // restart and dead rise together, then dead held high
        step(1, 0); run(200, 0);
        step(1, 1);
        check("sim_run", running, 1'b1);
        check("sim_cur", cur_time, 16'h0000);
        check("sim_best", best_time, 16'h0080);
        run(50, 1);
        check("deadhi_cnt", cur_time, 16'h0005);
        step(0, 0);
        step(0, 1);
        check("rearm_dead", running, 1'b0);

        // scan with no best recorded, passing through 0x1234
        do_reset();
        step(1, 0);
        run(12340, 0);
        check("scan_1234", cur_time, 16'h1234);
        run(64, 0);

        // randomized restarts and dead toggles
        dl = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            rr = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0) dl = ~dl;
            step(rr, dl);
        end

        // saturation on a tick-every-cycle instance
        restart_f = 1'b1;
        @(posedge clk);
        @(negedge clk);
        restart_f = 1'b0;
        for (int k = 1; k <= 10040; k++) begin
            @(posedge clk);
            #1;
            pre = (k - 1 > 9999) ? 9999 : k - 1;
            es = exp_scan(n_f, pre, 0, 1'b0);
            check("f_cur", cur_time_f, to_bcd((k > 9999) ? 9999 : k));
            check("f_run", running_f, 1'b1);
            check("f_bv", best_valid_f, 1'b0);
            check("f_best", best_time_f, 16'h0000);
            check("f_an", an_f, es[15:8]);
            check("f_cath", cath_f, es[7:0]);
        end
        check("f_sat", cur_time_f, 16'h9999);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
